// File: rtl/alu_16.sv
// 16-bit registered ALU: eight operations on optionally swapped operands,
// result and zero flag captured together one cycle after the inputs.
module alu_16 (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [2:0]  ALUct1,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Flip,
  output logic [15:0] ALUOut,
  output logic        Zero
);

  logic [15:0] x;
  logic [15:0] y;
  logic [3:0]  shamt;
  logic [15:0] res_d;
  logic [15:0] res_q;
  logic        zero_d;
  logic        zero_q;

  assign x     = Flip ? B : A;
  assign y     = Flip ? A : B;
  assign shamt = y[3:0];

  always_comb begin
    res_d = '0;
    unique case (ALUct1)
      3'd0: res_d = x & y;
      3'd1: res_d = x | y;
      3'd2: res_d = x + y;
      3'd3: res_d = x ^ y;
      3'd4: res_d = x << shamt;
      3'd5: res_d = x >> shamt;
      3'd6: res_d = x - y;
      3'd7: res_d = {15'd0, (x < y)};
      default: res_d = '0;
    endcase
    zero_d = (res_d == 16'h0000);
  end

  // Reset forces the cleared result with its matching flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      res_q  <= 16'h0000;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end

  assign ALUOut = res_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: arithmetic reference model checked
// every cycle, plus directed vectors with literal expected results.
module tb_alu_16;

  logic        CLK;
  logic        Reset;
  logic [2:0]  ALUct1;
  logic [15:0] A;
  logic [15:0] B;
  logic        Flip;
  logic [15:0] ALUOut;
  logic        Zero;

  int n_total;
  int n_pass;
  bit chk_en;

  alu_16 dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .ALUct1 (ALUct1),
    .A      (A),
    .B      (B),
    .Flip   (Flip),
    .ALUOut (ALUOut),
    .Zero   (Zero)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int model(input int op, input int a,
                               input int b, input bit f);
    int x;
    int y;
    int s;
    x = f ? b : a;
    y = f ? a : b;
    s = y % 16;
    case (op)
      0: return x & y;
      1: return x | y;
      2: return (x + y) % 65536;
      3: return x ^ y;
      4: return (x * (1 << s)) % 65536;
      5: return x / (1 << s);
      6: return (x - y + 65536) % 65536;
      default: return (x < y) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic gz, input logic [15:0] exp,
                       input logic ez);
    n_total++;
    if (got === exp && gz === ez) n_pass++;
    else $display("FAIL %s: ALUOut=%h Zero=%b, required ALUOut=%h Zero=%b",
                  name, got, gz, exp, ez);
  endtask

  // Reference compare: every cycle once enabled.
  initial begin
    int e;
    forever begin
      @(posedge CLK);
      if (Reset) e = 0;
      else e = model(int'(ALUct1), int'(A), int'(B), Flip);
      #1;
      if (chk_en)
        check("model", ALUOut, Zero, 16'(e), (e == 0));
    end
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic f);
    @(negedge CLK);
    ALUct1 = op;
    A      = a;
    B      = b;
    Flip   = f;
  endtask

  task automatic expect_lit(input string name, input logic [15:0] exp,
                            input logic ez);
    @(posedge CLK);
    #2;
    check(name, ALUOut, Zero, exp, ez);
  endtask

  initial begin
    logic [15:0] held;
    logic        heldz;
    n_total = 0;
    n_pass  = 0;
    chk_en  = 1'b0;
    Reset   = 1'b1;
    ALUct1  = 3'd2;
    A       = 16'h1234;
    B       = 16'h4321;
    Flip    = 1'b0;

    repeat (2) @(posedge CLK);
    #2;
    check("reset", ALUOut, Zero, 16'h0000, 1'b1);

    @(negedge CLK);
    Reset = 1'b0;
    chk_en = 1'b1;
    drive(3'd2, 16'h0003, 16'h0004, 1'b0);
    expect_lit("add_first", 16'h0007, 1'b0);

    drive(3'd2, 16'hFF00, 16'h0100, 1'b0);
    expect_lit("add_wrap", 16'h0000, 1'b1);
    drive(3'd6, 16'h0005, 16'h0007, 1'b0);
    expect_lit("sub", 16'hFFFE, 1'b0);
    drive(3'd6, 16'h0005, 16'h0007, 1'b1);
    expect_lit("sub_flip", 16'h0002, 1'b0);
    drive(3'd7, 16'h0001, 16'hFF00, 1'b0);
    expect_lit("slt", 16'h0001, 1'b0);
    drive(3'd7, 16'h0001, 16'hFF00, 1'b1);
    expect_lit("slt_flip", 16'h0000, 1'b1);
    drive(3'd4, 16'h8001, 16'h0011, 1'b0);
    expect_lit("shl", 16'h0002, 1'b0);
    drive(3'd5, 16'h8000, 16'h000F, 1'b0);
    expect_lit("shr", 16'h0001, 1'b0);
    drive(3'd4, 16'hA5A5, 16'hFFF0, 1'b0);
    expect_lit("shl_zero_amt", 16'hA5A5, 1'b0);
    drive(3'd0, 16'hF0F0, 16'h0F0F, 1'b0);
    expect_lit("and_zero", 16'h0000, 1'b1);
    drive(3'd3, 16'hFFFF, 16'h00FF, 1'b1);
    expect_lit("xor_flip", 16'hFF00, 1'b0);
    drive(3'd1, 16'h1200, 16'h0034, 1'b0);
    expect_lit("or", 16'h1234, 1'b0);

    // Mid-cycle input and reset changes must not reach the outputs.
    held  = ALUOut;
    heldz = Zero;
    #1;
    A      = 16'h0000;
    ALUct1 = 3'd0;
    Reset  = 1'b1;
    #1;
    check("no_async", ALUOut, Zero, held, heldz);
    @(negedge CLK);
    Reset = 1'b0;

    // Strided sweep across 0xFF00..0x00FE, endpoints included.
    for (int oi = 0; oi < 5; oi++) begin
      logic [2:0] op;
      case (oi)
        0: op = 3'd0;
        1: op = 3'd1;
        2: op = 3'd2;
        3: op = 3'd6;
        default: op = 3'd7;
      endcase
      for (int i = 0; i <= 510; i += 30)
        for (int j = 0; j <= 510; j += 30)
          drive(op, 16'(16'hFF00 + i), 16'(16'hFF00 + j), 1'b0);
    end

    for (int k = 0; k < 300; k++)
      drive(3'($urandom_range(7)), 16'($urandom), 16'($urandom),
            1'($urandom_range(1)));

    @(negedge CLK);
    Reset = 1'b1;
    expect_lit("reset_again", 16'h0000, 1'b1);
    @(negedge CLK);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
